op_div_seq: RTL and testbench



---
 rtl/op_div_seq.sv | 130 +++++++++++++
 tb/tb_op_div_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/op_div_seq.sv
// Sequential restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// Started by a start/busy/done handshake. Divide-by-zero is flagged via overflow.
module op_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] y,
  output logic [7:0]  remainder,
  output logic        carry,
  output logic        overflow,
  output logic        negative,
  output logic        zero
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [15:0] q_q, q_d;
  logic [7:0]  d_q, d_d;
  logic [7:0]  r_q, r_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] y_q, y_d;
  logic [7:0]  rem_q, rem_d;
  logic        ovf_q, ovf_d;
  logic        dz_q, dz_d;

  logic [8:0]  step_t;
  logic [7:0]  step_diff;
  logic        step_take;

  // The partial remainder always stays below the divisor, so 8 bits suffice and the
  // subtraction can be done modulo 256 once the 9-bit compare has passed.
  assign step_t    = {r_q, q_q[15]};
  assign step_take = (step_t >= {1'b0, d_q});
  assign step_diff = step_t[7:0] - d_q;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    y_d     = y_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dz_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dz_q) begin
          y_d    = 16'hFFFF;
          rem_d  = q_q[7:0];
          ovf_d  = 1'b1;
          done_d = 1'b1;
        end else if (start) begin
          q_d   = dividend;
          d_d   = divisor;
          r_d   = 8'h00;
          cnt_d = 4'd15;
          if (divisor != 8'h00) begin
            state_d = RUN;
            busy_d  = 1'b1;
          end else begin
            dz_d = 1'b1;
          end
        end
      end
      RUN: begin
        r_d = step_take ? step_diff : step_t[7:0];
        q_d = {q_q[14:0], step_take};
        if (cnt_q == 4'd0) begin
          y_d     = {q_q[14:0], step_take};
          rem_d   = step_take ? step_diff : step_t[7:0];
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= 16'h0000;
      d_q     <= 8'h00;
      r_q     <= 8'h00;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= 16'h0000;
      rem_q   <= 8'h00;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      y_q     <= y_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign y         = y_q;
  assign remainder = rem_q;
  assign overflow  = ovf_q;
  assign carry     = 1'b0;
  assign negative  = y_q[15];
  assign zero      = (y_q == 16'h0000);

endmodule

// File: tb/tb_op_div_seq.sv
// Directed self-checking bench for op_div_seq: vector table, reference sweep and
// hand-written multi-cycle sequences (busy-ignore, back-to-back, mid-run reset).
module tb_op_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] y;
  logic [7:0]  remainder;
  logic        carry;
  logic        overflow;
  logic        negative;
  logic        zero;

  int checks;
  int fails;

  op_div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .y         (y),
    .remainder (remainder),
    .carry     (carry),
    .overflow  (overflow),
    .negative  (negative),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] exp_y;
    logic [7:0]  exp_rem;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one start pulse and wait (bounded) for done; lat counts edges after acceptance.
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b,
                               output int lat, output bit busy_seen);
    bit overlap;
    busy_seen = 0;
    overlap   = 0;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 40; i++) begin
      if (busy) busy_seen = 1;
      @(posedge clk);
      #1;
      if (done && busy) overlap = 1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_seen = 1;
    end
    checkOutput("done_with_busy", {31'd0, overlap}, 32'd0);
  endtask

  task automatic checkResult(input string tag, input logic [15:0] ey, input logic [7:0] er,
                             input logic eo);
    checkOutput({tag, "_y"}, {16'd0, y}, {16'd0, ey});
    checkOutput({tag, "_rem"}, {24'd0, remainder}, {24'd0, er});
    checkOutput({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
    checkOutput({tag, "_neg"}, {31'd0, negative}, {31'd0, ey[15]});
    checkOutput({tag, "_zero"}, {31'd0, zero}, {31'd0, (ey == 16'h0000)});
    checkOutput({tag, "_carry"}, {31'd0, carry}, 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkResult(tag, 16'h0000, 8'h00, 1'b0);
  endtask

  initial begin
    logic [15:0] sweep_a[10];
    logic [7:0]  sweep_b[5];
    int          lat;
    bit          busy_seen;
    int          ndone;
    logic [15:0] cap_y;
    logic [7:0]  cap_rem;

    checks = 0;
    fails  = 0;

    vecs[0] = '{16'h03E8, 8'd7,   16'h008E, 8'd6, 1'b0};
    vecs[1] = '{16'hFFFF, 8'hFF,  16'h0101, 8'd0, 1'b0};
    vecs[2] = '{16'h8000, 8'd1,   16'h8000, 8'd0, 1'b0};
    vecs[3] = '{16'h0003, 8'd10,  16'h0000, 8'd3, 1'b0};
    vecs[4] = '{16'h0005, 8'd0,   16'hFFFF, 8'd5, 1'b1};

    sweep_a = '{16'h0000, 16'h0001, 16'h007F, 16'h0080, 16'h00FF,
                16'h0100, 16'h7FFF, 16'h8000, 16'hFFFE, 16'hFFFF};
    sweep_b = '{8'h01, 8'h03, 8'h7F, 8'h80, 8'hFF};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 16'h0000;
    divisor  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, lat, busy_seen);
      checkOutput($sformatf("vec%0d_latency", i), lat, (vecs[i].b == 8'h00) ? 32'd1 : 32'd16);
      checkOutput($sformatf("vec%0d_busy_seen", i), {31'd0, busy_seen},
                  (vecs[i].b == 8'h00) ? 32'd0 : 32'd1);
      checkResult($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_rem, vecs[i].exp_ovf);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    $display("[TB] reference sweep");
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 5; j++) begin
        applyStimulus(sweep_a[i], sweep_b[j], lat, busy_seen);
        checkOutput($sformatf("sweep_%0h_%0h_lat", sweep_a[i], sweep_b[j]), lat, 32'd16);
        checkResult($sformatf("sweep_%0h_%0h", sweep_a[i], sweep_b[j]),
                    sweep_a[i] / {8'd0, sweep_b[j]},
                    8'((sweep_a[i] % {8'd0, sweep_b[j]})), 1'b0);
      end
    end

    $display("[TB] start while busy is ignored");
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dividend = 16'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    ndone   = 0;
    cap_y   = 16'h0000;
    cap_rem = 8'h00;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        cap_y   = y;
        cap_rem = remainder;
      end
    end
    checkOutput("busy_ignore_done_count", ndone, 32'd1);
    checkOutput("busy_ignore_y", {16'd0, cap_y}, 32'd142);
    checkOutput("busy_ignore_rem", {24'd0, cap_rem}, 32'd6);

    $display("[TB] back-to-back issue");
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    lat      = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    checkOutput("b2b_first_latency", lat, 32'd17);
    checkResult("b2b_first", 16'd142, 8'd6, 1'b0);
    dividend = 16'd50;
    divisor  = 8'd5;
    lat      = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    checkOutput("b2b_second_spacing", lat, 32'd17);
    checkResult("b2b_second", 16'd10, 8'd0, 1'b0);
    repeat (20) @(posedge clk);
    #1;

    $display("[TB] reset in the middle of a run");
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("midrun_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkResetValues("midrun_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    checkOutput("midrun_no_done", ndone, 32'd0);
    applyStimulus(16'd1000, 8'd7, lat, busy_seen);
    checkOutput("after_reset_latency", lat, 32'd16);
    checkResult("after_reset", 16'd142, 8'd6, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
